// File: rtl/memory_host.sv
// Single-port word-organised RAM serving the core's host memory interface.
// One command at a time, Latency wait cycles, one-cycle DONE with error flag and read data.
module memory_host #(
    parameter int DepthWords = 1024,
    parameter int Latency    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  cCommand,
    input  logic [31:0] cAddress,
    input  logic [31:0] cData,
    output logic        hReady,
    output logic        hSignal,
    output logic [31:0] hData
);

    localparam int AW = $clog2(DepthWords);
    localparam logic [32:0] BYTE_LIMIT = 33'(64'(DepthWords) * 64'd4);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_RB  = 3'd1;
    localparam logic [2:0] CMD_RH  = 3'd2;
    localparam logic [2:0] CMD_RW  = 3'd3;
    localparam logic [2:0] CMD_WB  = 3'd4;
    localparam logic [2:0] CMD_WH  = 3'd5;
    localparam logic [2:0] CMD_WW  = 3'd6;
    localparam logic [2:0] CMD_RSV = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic access_error(input logic [2:0] cmd, input logic [31:0] addr);
        logic half_acc;
        logic word_acc;
        logic out_of_range;
        half_acc     = (cmd == CMD_RH) || (cmd == CMD_WH);
        word_acc     = (cmd == CMD_RW) || (cmd == CMD_WW);
        out_of_range = ({1'b0, addr} >= BYTE_LIMIT);
        return (cmd == CMD_RSV) || out_of_range || (half_acc && addr[0])
               || (word_acc && (addr[1:0] != 2'b00));
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [AW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [31:0]     hdata_q, hdata_d;
    logic            hsig_q, hsig_d;

    logic [31:0]     mem_q [DepthWords];

    logic            done_entry_s;
    logic [2:0]      acc_cmd_s;
    logic [AW+1:0]   acc_addr_s;
    logic [31:0]     acc_data_s;
    logic            acc_err_s;
    logic [31:0]     rd_word_s;
    logic            we_s;
    logic [3:0]      be_s;
    logic [31:0]     wlane_s;

    // With Latency 0 the access happens on the accept edge, so it must see the live inputs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_cmd_s  = cCommand;
            acc_addr_s = cAddress[AW+1:0];
            acc_data_s = cData;
            acc_err_s  = access_error(cCommand, cAddress);
        end else begin
            acc_cmd_s  = cmd_q;
            acc_addr_s = addr_q;
            acc_data_s = wdata_q;
            acc_err_s  = err_q;
        end
        rd_word_s = mem_q[acc_addr_s[AW+1:2]];
    end

    // Next-state, capture and access-result logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        hdata_d      = hdata_q;
        hsig_d       = hsig_q;
        done_entry_s = 1'b0;
        we_s         = 1'b0;
        be_s         = 4'b0000;
        wlane_s      = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                if (cCommand != CMD_NOP) begin
                    cmd_d   = cCommand;
                    addr_d  = cAddress[AW+1:0];
                    wdata_d = cData;
                    err_d   = access_error(cCommand, cAddress);
                    if (Latency == 0) begin
                        state_d      = ST_DONE;
                        done_entry_s = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 4'(Latency - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_DONE;
                    done_entry_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done_entry_s) begin
            if (acc_err_s) begin
                hsig_d  = 1'b1;
                hdata_d = 32'h0000_0000;
            end else begin
                hsig_d = 1'b0;
                case (acc_cmd_s)
                    CMD_RB: hdata_d = {24'h00_0000, rd_word_s[{acc_addr_s[1:0], 3'b000} +: 8]};
                    CMD_RH: hdata_d = {16'h0000, rd_word_s[{acc_addr_s[1], 4'b0000} +: 16]};
                    CMD_RW: hdata_d = rd_word_s;
                    CMD_WB: begin
                        hdata_d = 32'h0000_0000;
                        we_s    = 1'b1;
                        be_s    = 4'b0001 << acc_addr_s[1:0];
                        wlane_s = {4{acc_data_s[7:0]}};
                    end
                    CMD_WH: begin
                        hdata_d = 32'h0000_0000;
                        we_s    = 1'b1;
                        be_s    = acc_addr_s[1] ? 4'b1100 : 4'b0011;
                        wlane_s = {2{acc_data_s[15:0]}};
                    end
                    CMD_WW: begin
                        hdata_d = 32'h0000_0000;
                        we_s    = 1'b1;
                        be_s    = 4'b1111;
                        wlane_s = acc_data_s;
                    end
                    default: hdata_d = 32'h0000_0000;
                endcase
            end
        end else begin
            hsig_d = hsig_q;
        end
    end

    // Host ready: idle-and-NOP handshake or the single completion cycle.
    always_comb begin
        case (state_q)
            ST_IDLE: hReady = (cCommand == CMD_NOP);
            ST_BUSY: hReady = 1'b0;
            ST_DONE: hReady = 1'b1;
            default: hReady = 1'b0;
        endcase
    end

    // Controller state and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            hdata_q <= 32'h0000_0000;
            hsig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            hdata_q <= hdata_d;
            hsig_q  <= hsig_d;
        end
    end

    // RAM array is not reset; a held reset blocks any commit so aborted writes are dropped.
    always_ff @(posedge clock) begin
        if (reset && we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[acc_addr_s[AW+1:2]][8*b +: 8] <= wlane_s[8*b +: 8];
                end
            end
        end
    end

    assign hData   = hdata_q;
    assign hSignal = hsig_q;

endmodule

// File: tb/tb_memory_host.sv
// Scoreboard bench for memory_host: three instances (Latency 2, 0, 15) driven by
// directed vectors; a monitor pops expected completions whenever a DONE cycle is seen.
module tb_memory_host;

    logic              clock = 1'b0;
    logic              reset;
    logic [2:0][2:0]   cmd;
    logic [2:0][31:0]  addr;
    logic [2:0][31:0]  wdat;
    logic [2:0]        rdy;
    logic [2:0]        sig;
    logic [2:0][31:0]  hd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          inst;
        logic [31:0] data;
        logic        sig;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    memory_host #(.DepthWords(1024), .Latency(2)) dut_l2 (
        .clock(clock), .reset(reset), .cCommand(cmd[0]), .cAddress(addr[0]), .cData(wdat[0]),
        .hReady(rdy[0]), .hSignal(sig[0]), .hData(hd[0]));
    memory_host #(.DepthWords(1024), .Latency(0)) dut_l0 (
        .clock(clock), .reset(reset), .cCommand(cmd[1]), .cAddress(addr[1]), .cData(wdat[1]),
        .hReady(rdy[1]), .hSignal(sig[1]), .hData(hd[1]));
    memory_host #(.DepthWords(1024), .Latency(15)) dut_l15 (
        .clock(clock), .reset(reset), .cCommand(cmd[2]), .cAddress(addr[2]), .cData(wdat[2]),
        .hReady(rdy[2]), .hSignal(sig[2]), .hData(hd[2]));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 15);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a DONE cycle is hReady high while the client still holds its command.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (rdy[i] === 1'b1 && cmd[i] != 3'd0) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: inst %0d completed with nothing expected", i);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk({e.name, "_inst"}, 32'(i), 32'(e.inst));
                        chk({e.name, "_data"}, hd[i], e.data);
                        chk({e.name, "_sig"}, {31'd0, sig[i]}, {31'd0, e.sig});
                        chk({e.name, "_cycle"}, 32'(cyc), 32'(e.done_cyc));
                    end
                end
            end
        end
    end

    task automatic run(input int i, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] edata, input logic esig,
                       input string nm);
        bit seen;
        exp_t e;
        @(posedge clock);
        #1;
        cmd[i]  = c;
        addr[i] = a;
        wdat[i] = d;
        e.inst = i; e.data = edata; e.sig = esig; e.done_cyc = cyc + 1 + lat_of(i); e.name = nm;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            if (rdy[i] === 1'b1) seen = 1'b1;
            else if (k == 1) begin
                addr[i] = ~a;
                wdat[i] = ~d;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no completion within 40 cycles, expected one", nm);
        end
        @(posedge clock);
        #1;
        cmd[i] = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        cmd   = '0;
        addr  = '0;
        wdat  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("reset_ready",  {31'd0, rdy[0]}, 32'd1);
        chk("reset_signal", {31'd0, sig[0]}, 32'd0);
        chk("reset_data",   hd[0], 32'h0000_0000);

        run(0, 3'd6, 32'h800,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "ww_800");
        run(0, 3'd3, 32'h800,  32'h0,         32'hDEAD_BEEF, 1'b0, "rw_800");
        run(0, 3'd4, 32'h801,  32'hFFFF_FF12, 32'h0000_0000, 1'b0, "wb_801");
        run(0, 3'd3, 32'h800,  32'h0,         32'hDEAD_12EF, 1'b0, "rw_after_wb");
        run(0, 3'd2, 32'h802,  32'h0,         32'h0000_DEAD, 1'b0, "rh_802");
        run(0, 3'd1, 32'h803,  32'h0,         32'h0000_00DE, 1'b0, "rb_803");
        run(0, 3'd1, 32'h800,  32'h0,         32'h0000_00EF, 1'b0, "rb_800");
        run(0, 3'd2, 32'h800,  32'h0,         32'h0000_12EF, 1'b0, "rh_800");
        run(0, 3'd5, 32'h802,  32'hFFFF_1234, 32'h0000_0000, 1'b0, "wh_802");
        run(0, 3'd3, 32'h800,  32'h0,         32'h1234_12EF, 1'b0, "rw_after_wh");

        run(0, 3'd3, 32'h802,  32'h0,         32'h0000_0000, 1'b1, "rw_misaligned");
        run(0, 3'd2, 32'h801,  32'h0,         32'h0000_0000, 1'b1, "rh_misaligned");
        run(0, 3'd6, 32'h0,    32'hA5A5_0001, 32'h0000_0000, 1'b0, "ww_0");
        run(0, 3'd6, 32'h1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "ww_range");
        run(0, 3'd3, 32'h0,    32'h0,         32'hA5A5_0001, 1'b0, "rw_0_unchanged");
        run(0, 3'd7, 32'h0,    32'h0,         32'h0000_0000, 1'b1, "cmd_reserved");
        run(0, 3'd4, 32'hFFF,  32'h0000_0077, 32'h0000_0000, 1'b0, "wb_last");
        run(0, 3'd1, 32'hFFF,  32'h0,         32'h0000_0077, 1'b0, "rb_last");
        run(0, 3'd1, 32'h1000, 32'h0,         32'h0000_0000, 1'b1, "rb_range");

        run(1, 3'd6, 32'h800,  32'hCAFE_F00D, 32'h0000_0000, 1'b0, "l0_ww");
        run(1, 3'd3, 32'h800,  32'h0,         32'hCAFE_F00D, 1'b0, "l0_rw");
        run(2, 3'd6, 32'h800,  32'h0BAD_F00D, 32'h0000_0000, 1'b0, "l15_ww");
        run(2, 3'd3, 32'h800,  32'h0,         32'h0BAD_F00D, 1'b0, "l15_rw");

        // Write abort: reset lands while the overwrite is in BUSY.
        run(0, 3'd6, 32'h804,  32'h1122_3344, 32'h0000_0000, 1'b0, "ww_804");
        run(0, 3'd3, 32'h800,  32'h0,         32'h1234_12EF, 1'b0, "rw_before_abort");
        @(posedge clock);
        #1;
        cmd[0]  = 3'd6;
        addr[0] = 32'h804;
        wdat[0] = 32'h0000_0055;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        cmd[0] = 3'd0;
        @(negedge clock);
        chk("abort_ready",  {31'd0, rdy[0]}, 32'd1);
        chk("abort_signal", {31'd0, sig[0]}, 32'd0);
        chk("abort_data",   hd[0], 32'h0000_0000);
        #2;
        reset = 1'b1;
        @(negedge clock);
        chk("post_abort_ready", {31'd0, rdy[0]}, 32'd1);
        run(0, 3'd3, 32'h804,  32'h0,         32'h1122_3344, 1'b0, "rw_804_after_abort");

        repeat (3) @(posedge clock);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
